// File: rtl/orgunit_sysreg_unit.sv
// Elastic system-register unit: each accepted token gets NUM_CH system values
// written into its EV image, then queues in a DEPTH-entry valid/ready FIFO.
module orgunit_sysreg_unit #(
  parameter int EV_WORDS = 16,
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 2,
  parameter int ID_W     = 32,
  parameter int ADDR_W   = 32,
  parameter int LOC_W    = $clog2(EV_WORDS) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EV_WORDS*64-1:0]    in_env,
  input  logic [ID_W-1:0]           in_id,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [NUM_CH*LOC_W-1:0]   in_loc,
  input  logic [NUM_CH*3-1:0]       in_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EV_WORDS*64-1:0]    out_env,
  output logic [ID_W-1:0]           out_id,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [63:0]               retired_count,
  output logic                      err_loc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]      CNT_ONE  = 1;
  localparam logic [PW:0]      CNT_FULL = DEPTH[PW:0];
  localparam logic [PW-1:0]    PTR_ONE  = 1;
  localparam logic [LOC_W-1:0] LOC_LIM  = EV_WORDS[LOC_W-1:0];

  logic [PW:0]            count_q, count_d;
  logic [PW-1:0]          wptr_q, rptr_q;
  logic [63:0]            cyc_q, ret_q;
  logic                   err_q;
  logic [EV_WORDS*64-1:0] env_mem [DEPTH];
  logic [ID_W-1:0]        id_mem  [DEPTH];
  logic [ADDR_W-1:0]      addr_mem[DEPTH];

  logic                   push, pop, hit_err;
  logic [EV_WORDS*64-1:0] upd_env;

  assign in_ready      = (count_q < CNT_FULL);
  assign out_valid     = (count_q != '0);
  assign push          = in_valid & in_ready;
  assign pop           = out_valid & out_ready;
  assign out_env       = out_valid ? env_mem[rptr_q]  : '0;
  assign out_id        = out_valid ? id_mem[rptr_q]   : '0;
  assign out_addr      = out_valid ? addr_mem[rptr_q] : '0;
  assign retired_count = ret_q;
  assign err_loc       = err_q;

  // Channels applied in ascending order so the highest channel wins a shared slot.
  always_comb begin
    upd_env = in_env;
    hit_err = 1'b0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      logic [LOC_W-1:0] loc;
      logic [2:0]       sel;
      logic [63:0]      val;
      logic             wr;
      loc = in_loc[ch*LOC_W +: LOC_W];
      sel = in_sel[ch*3 +: 3];
      val = '0;
      wr  = 1'b1;
      case (sel)
        3'd1:    val = 64'(in_id);
        3'd2:    val = 64'(in_addr);
        3'd3:    val = cyc_q;
        3'd4:    val = ret_q;
        3'd5:    val = 64'(in_id) * 64'(NUM_CH) + 64'(ch);
        default: wr  = 1'b0;
      endcase
      if (wr) begin
        if (loc < LOC_LIM) upd_env[int'(loc)*64 +: 64] = val;
        else               hit_err = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cyc_q   <= cyc_q + 64'd1;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (push && hit_err) err_q <= 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
        ret_q  <= ret_q + 64'd1;
      end
    end
  end

  // Payload storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      env_mem[wptr_q]  <= upd_env;
      id_mem[wptr_q]   <= in_id;
      addr_mem[wptr_q] <= in_addr;
    end
  end

endmodule

// File: tb/tb_orgunit_sysreg_unit.sv
// Bench for orgunit_sysreg_unit: queue-based reference model checked every cycle,
// directed tokens with literal expectations, then randomized traffic.
module tb_orgunit_sysreg_unit;
  localparam int EVW  = 16;
  localparam int NCH  = 2;
  localparam int DEP  = 2;
  localparam int LW   = 5;
  localparam int ENVB = EVW*64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0, in_ready;
  logic [ENVB-1:0] in_env = '0;
  logic [31:0]     in_id = '0, in_addr = '0;
  logic [NCH*LW-1:0] in_loc = '0;
  logic [NCH*3-1:0]  in_sel = '0;
  logic            out_valid, out_ready = 1'b0;
  logic [ENVB-1:0] out_env;
  logic [31:0]     out_id, out_addr;
  logic [63:0]     retired_count;
  logic            err_loc;

  always #5 clk = ~clk;

  orgunit_sysreg_unit #(.EV_WORDS(EVW), .NUM_CH(NCH), .DEPTH(DEP), .ID_W(32), .ADDR_W(32))
  dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_env(in_env), .in_id(in_id), .in_addr(in_addr), .in_loc(in_loc), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_env(out_env), .out_id(out_id),
    .out_addr(out_addr), .retired_count(retired_count), .err_loc(err_loc)
  );

  typedef struct {
    logic [ENVB-1:0] env;
    logic [31:0]     id;
    logic [31:0]     addr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mcyc, mret;
  logic        merr;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_env(input string name, input logic [ENVB-1:0] act, input logic [ENVB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      for (int k = 0; k < EVW; k++)
        if (act[k*64 +: 64] !== exp[k*64 +: 64]) begin
          $display("FAIL %s slot%0d: got %h expected %h", name, k, act[k*64 +: 64], exp[k*64 +: 64]);
          break;
        end
    end
  endtask

  function automatic logic [63:0] slot(input logic [ENVB-1:0] e, input int k);
    return e[k*64 +: 64];
  endfunction

  task automatic model_clear();
    mq.delete();
    mcyc = '0;
    mret = '0;
    merr = 1'b0;
  endtask

  // Predicts what the upcoming rising edge does, from the inputs currently driven.
  task automatic model_edge();
    bit   acc, pp;
    ent_t e;
    logic [63:0] s[EVW];
    acc = in_valid && (mq.size() < DEP);
    pp  = (mq.size() > 0) && out_ready;
    if (acc) begin
      for (int k = 0; k < EVW; k++) s[k] = slot(in_env, k);
      for (int ch = 0; ch < NCH; ch++) begin
        int sel, loc;
        logic [63:0] v;
        sel = int'(in_sel[ch*3 +: 3]);
        loc = int'(in_loc[ch*LW +: LW]);
        v = '0;
        if (sel >= 1 && sel <= 5) begin
          case (sel)
            1: v = {32'h0, in_id};
            2: v = {32'h0, in_addr};
            3: v = mcyc;
            4: v = mret;
            default: v = {32'h0, in_id} * 64'(NCH) + 64'(ch);
          endcase
          if (loc >= EVW) merr = 1'b1;
          else            s[loc] = v;
        end
      end
      for (int k = 0; k < EVW; k++) e.env[k*64 +: 64] = s[k];
      e.id   = in_id;
      e.addr = in_addr;
    end
    if (pp) begin
      void'(mq.pop_front());
      mret = mret + 64'd1;
    end
    if (acc) mq.push_back(e);
    mcyc = mcyc + 64'd1;
  endtask

  task automatic check_all();
    bit ne;
    ne = mq.size() > 0;
    chk("in_ready", 64'(in_ready), 64'(mq.size() < DEP));
    chk("out_valid", 64'(out_valid), 64'(ne));
    chk("out_id", 64'(out_id), ne ? 64'(mq[0].id) : 64'd0);
    chk("out_addr", 64'(out_addr), ne ? 64'(mq[0].addr) : 64'd0);
    chk_env("out_env", out_env, ne ? mq[0].env : '0);
    chk("retired_count", retired_count, mret);
    chk("err_loc", 64'(err_loc), 64'(merr));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst retired", retired_count, 64'd0);
    chk("rst err_loc", 64'(err_loc), 64'd0);
    chk("rst out_id", 64'(out_id), 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_env();
    for (int k = 0; k < ENVB/32; k++) in_env[k*32 +: 32] = $urandom;
  endtask

  task automatic set_tok(input logic [31:0] id, input logic [31:0] addr,
                         input int l0, input int s0, input int l1, input int s1);
    rand_env();
    in_id   = id;
    in_addr = addr;
    in_loc  = {l1[LW-1:0], l0[LW-1:0]};
    in_sel  = {s1[2:0], s0[2:0]};
  endtask

  // Offer one token for one edge, check the result, then let it retire.
  task automatic one_tok(input logic [31:0] id, input logic [31:0] addr,
                         input int l0, input int s0, input int l1, input int s1);
    set_tok(id, addr, l0, s0, l1, s1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [ENVB-1:0] env_saved;
    model_clear();
    out_ready = 1'b1;
    do_reset();

    while (mcyc < 64'd10) tick();
    one_tok(32'h9, 32'h0, 0, 3, 0, 0);
    chk("cycle@10", slot(out_env, 0), 64'd10);
    tick();

    one_tok(32'h5, 32'h1000, 3, 1, 7, 2);
    env_saved = in_env;
    chk("basic slot3", slot(out_env, 3), 64'h5);
    chk("basic slot7", slot(out_env, 7), 64'h1000);
    chk("basic slot0", slot(out_env, 0), slot(env_saved, 0));
    tick();

    one_tok(32'h7, 32'h0, 9, 4, 0, 0);
    chk("retired sel", slot(out_env, 9), 64'd2);
    tick();

    one_tok(32'h11, 32'hABCD, 4, 1, 4, 2);
    chk("dup ch1 wins", slot(out_env, 4), 64'hABCD);
    tick();
    one_tok(32'h11, 32'h1234, 4, 2, 4, 0);
    chk("dup sel0", slot(out_env, 4), 64'h1234);
    tick();

    one_tok(32'h3, 32'h0, 1, 5, 2, 5);
    chk("lane ch0", slot(out_env, 1), 64'd6);
    chk("lane ch1", slot(out_env, 2), 64'd7);
    tick();

    one_tok(32'h22, 32'h0, 15, 6, 17, 7);
    chk("reserved no err", 64'(err_loc), 64'd0);
    tick();

    one_tok(32'h44, 32'h0, 16, 1, 2, 1);
    env_saved = in_env;
    chk("oor slot2", slot(out_env, 2), 64'h44);
    chk("oor slot0", slot(out_env, 0), slot(env_saved, 0));
    chk("oor err", 64'(err_loc), 64'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      one_tok($urandom, $urandom, int'($urandom_range(0, 15)), 1, 0, 0);
      tick();
    end
    chk("err sticky", 64'(err_loc), 64'd1);

    do_reset();
    out_ready = 1'b0;
    set_tok(32'd1, 32'h100, 0, 1, 1, 2);
    in_valid = 1'b1;
    tick();
    set_tok(32'd2, 32'h200, 0, 1, 1, 2);
    tick();
    chk("bp full", 64'(in_ready), 64'd0);
    set_tok(32'd3, 32'h300, 0, 1, 1, 2);
    tick();
    chk("bp held", 64'(in_ready), 64'd0);
    chk("bp head1", 64'(out_id), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp head2", 64'(out_id), 64'd2);
    tick();
    chk("bp head3", 64'(out_id), 64'd3);
    in_valid = 1'b0;
    tick();
    chk("bp retired", retired_count, 64'd3);
    chk("bp empty", 64'(out_valid), 64'd0);

    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      set_tok($urandom, $urandom,
              int'($urandom_range(0, 18)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 18)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 7) == 0) in_id = 32'hFFFF_FFFF;
      tick();
    end

    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_tok(32'hA, 32'hB, 0, 1, 1, 2);
    while (mq.size() < DEP) tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async in_ready", 64'(in_ready), 64'd1);
    chk("async retired", retired_count, 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    one_tok(32'h1, 32'h2, 5, 3, 6, 4);
    chk("post-reset cycle", slot(out_env, 5), 64'd0);
    chk("post-reset retired", slot(out_env, 6), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
